axi_read_arbiter_rr: RTL and testbench

Parametrised read-path controller for the AXI interconnect. It decodes each master's AR address against per-slave address windows and arbitrates AR requests round-robin among NUM_MASTERS masters. It locks each slave to the winning master until the slave's RLAST beat is accepted, and routes R-channel handshakes by that ownership. Unmapped addresses receive a single-beat DECERR response generated internally. It sits between the master-side and slave-side mux/demux datapaths and drives their select lines.

---
 rtl/axi_read_arbiter_rr.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_read_arbiter_rr.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter_rr.sv
// Read-path controller: decodes AR addresses to slave windows, arbitrates masters round-robin,
// locks each slave to its winning master until RLAST, and answers unmapped reads with DECERR.
module axi_read_arbiter_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SLAVES*ADDR_W-1:0]  slave_addr_lo,
    input  logic [NUM_SLAVES*ADDR_W-1:0]  slave_addr_hi,
    input  logic [NUM_MASTERS*ADDR_W-1:0] M_ARADDR,
    input  logic [NUM_MASTERS-1:0]        M_ARVALID,
    input  logic [NUM_MASTERS-1:0]        M_RREADY,
    input  logic [NUM_SLAVES-1:0]         S_ARREADY,
    input  logic [NUM_SLAVES-1:0]         S_RVALID,
    input  logic [NUM_SLAVES-1:0]         S_RLAST,
    output logic [NUM_MASTERS-1:0]        ar_grant,
    output logic [MW-1:0]                 ar_sel_master,
    output logic [SW-1:0]                 ar_sel_slave,
    output logic [NUM_SLAVES-1:0]         S_ARVALID,
    output logic [NUM_MASTERS-1:0]        M_ARREADY,
    output logic [NUM_MASTERS*SW-1:0]     r_sel_slave,
    output logic [NUM_MASTERS-1:0]        M_RVALID,
    output logic [NUM_MASTERS-1:0]        M_RLAST,
    output logic [NUM_MASTERS-1:0]        M_RDECERR,
    output logic [NUM_SLAVES-1:0]         S_RREADY,
    output logic [NUM_SLAVES-1:0]         slave_busy
);

    typedef enum logic [0:0] {ST_IDLE, ST_ADDR} state_t;

    state_t                 state_reg, state_next;
    logic [MW-1:0]          rr_ptr_reg, rr_ptr_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [MW-1:0]          sel_master_reg, sel_master_next;
    logic [SW-1:0]          sel_slave_reg, sel_slave_next;
    logic                   miss_reg, miss_next;

    logic [NUM_SLAVES-1:0]  busy_reg;
    logic [MW-1:0]          owner_reg [NUM_SLAVES];
    logic [NUM_MASTERS-1:0] outstanding_reg;
    logic [NUM_MASTERS-1:0] decerr_reg;

    logic [NUM_MASTERS*SW-1:0] dec_slave_flat;
    logic [NUM_MASTERS-1:0]    dec_miss;
    logic [NUM_MASTERS-1:0]    eligible;

    logic                   pick_found;
    logic [MW-1:0]          pick_idx;
    logic                   ar_hs;

    genvar gi, gj;

    // Per-master address decode; the lowest-numbered matching window wins.
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_decode
            logic [ADDR_W-1:0]     addr;
            logic [NUM_SLAVES-1:0] hit;
            logic [SW-1:0]         tgt;

            assign addr = M_ARADDR[gi*ADDR_W +: ADDR_W];

            for (gj = 0; gj < NUM_SLAVES; gj++) begin : g_win
                assign hit[gj] = (addr >= slave_addr_lo[gj*ADDR_W +: ADDR_W]) &&
                                 (addr <= slave_addr_hi[gj*ADDR_W +: ADDR_W]);
            end

            always_comb begin
                tgt = '0;
                for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
                    if (hit[s]) begin
                        tgt = SW'(s);
                    end
                end
            end

            assign dec_slave_flat[gi*SW +: SW] = tgt;
            assign dec_miss[gi]                = ~|hit;
            assign eligible[gi] = M_ARVALID[gi] & ~outstanding_reg[gi] &
                                  (dec_miss[gi] | ~busy_reg[tgt]);
        end
    endgenerate

    // Round-robin pick: first eligible master at or after rr_ptr.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!pick_found && eligible[idx]) begin
                pick_found = 1'b1;
                pick_idx   = MW'(idx);
            end
        end
    end

    always_comb begin
        S_ARVALID = '0;
        M_ARREADY = '0;
        if (state_reg == ST_ADDR) begin
            if (miss_reg) begin
                M_ARREADY[sel_master_reg] = 1'b1;
            end else begin
                S_ARVALID[sel_slave_reg]  = 1'b1;
                M_ARREADY[sel_master_reg] = S_ARREADY[sel_slave_reg];
            end
        end
    end

    assign ar_hs = (state_reg == ST_ADDR) &&
                   M_ARVALID[sel_master_reg] && M_ARREADY[sel_master_reg];

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        grant_next      = grant_reg;
        sel_master_next = sel_master_reg;
        sel_slave_next  = sel_slave_reg;
        miss_next       = miss_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next      = ST_ADDR;
                    grant_next      = NUM_MASTERS'(1) << pick_idx;
                    sel_master_next = pick_idx;
                    sel_slave_next  = dec_slave_flat[pick_idx*SW +: SW];
                    miss_next       = dec_miss[pick_idx];
                end
            end
            ST_ADDR: begin
                // The grant is held until the master completes the handshake.
                if (ar_hs) begin
                    state_next  = ST_IDLE;
                    grant_next  = '0;
                    rr_ptr_next = (sel_master_reg == MW'(NUM_MASTERS - 1)) ?
                                  '0 : sel_master_reg + MW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            grant_reg      <= '0;
            sel_master_reg <= '0;
            sel_slave_reg  <= '0;
            miss_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            grant_reg      <= grant_next;
            sel_master_reg <= sel_master_next;
            sel_slave_reg  <= sel_slave_next;
            miss_reg       <= miss_next;
        end
    end

    // Ownership: releases first, then new locks, so a release and a grant on different
    // slaves land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg        <= '0;
            outstanding_reg <= '0;
            decerr_reg      <= '0;
            for (int s = 0; s < NUM_SLAVES; s++) begin
                owner_reg[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                if (busy_reg[s] && S_RVALID[s] && S_RREADY[s] && S_RLAST[s]) begin
                    busy_reg[s]                   <= 1'b0;
                    outstanding_reg[owner_reg[s]] <= 1'b0;
                end
            end
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (decerr_reg[m] && M_RREADY[m]) begin
                    decerr_reg[m]      <= 1'b0;
                    outstanding_reg[m] <= 1'b0;
                end
            end
            if (ar_hs) begin
                outstanding_reg[sel_master_reg] <= 1'b1;
                if (miss_reg) begin
                    decerr_reg[sel_master_reg] <= 1'b1;
                end else begin
                    busy_reg[sel_slave_reg]  <= 1'b1;
                    owner_reg[sel_slave_reg] <= sel_master_reg;
                end
            end
        end
    end

    // R routing is purely combinational on the registered ownership table.
    always_comb begin
        S_RREADY    = '0;
        M_RVALID    = decerr_reg;
        M_RLAST     = decerr_reg;
        M_RDECERR   = decerr_reg;
        r_sel_slave = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (busy_reg[s]) begin
                S_RREADY[s]                        = M_RREADY[owner_reg[s]];
                M_RVALID[owner_reg[s]]             = S_RVALID[s];
                M_RLAST[owner_reg[s]]              = S_RLAST[s];
                r_sel_slave[owner_reg[s]*SW +: SW] = SW'(s);
            end
        end
    end

    assign ar_grant      = grant_reg;
    assign ar_sel_master = sel_master_reg;
    assign ar_sel_slave  = sel_slave_reg;
    assign slave_busy    = busy_reg;

endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
// Directed bench for axi_read_arbiter_rr: two masters, four 256 MB slave windows
// starting at address zero; everything above 0x3FFF_FFFF is unmapped.
module tb_axi_read_arbiter_rr;

    localparam int NM = 2;
    localparam int NS = 4;
    localparam int AW = 32;

    logic            clk;
    logic            reset;
    logic [NS*AW-1:0] addr_lo, addr_hi;
    logic [NM*AW-1:0] m_araddr;
    logic [NM-1:0]   m_arvalid, m_rready;
    logic [NS-1:0]   s_arready, s_rvalid, s_rlast;
    logic [NM-1:0]   ar_grant;
    logic            ar_sel_master;
    logic [1:0]      ar_sel_slave;
    logic [NS-1:0]   s_arvalid_o;
    logic [NM-1:0]   m_arready_o;
    logic [NM*2-1:0] r_sel_slave;
    logic [NM-1:0]   m_rvalid_o, m_rlast_o, m_rdecerr_o;
    logic [NS-1:0]   s_rready_o;
    logic [NS-1:0]   slave_busy;

    int compared   = 0;
    int mismatched = 0;

    axi_read_arbiter_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .slave_addr_lo (addr_lo),
        .slave_addr_hi (addr_hi),
        .M_ARADDR      (m_araddr),
        .M_ARVALID     (m_arvalid),
        .M_RREADY      (m_rready),
        .S_ARREADY     (s_arready),
        .S_RVALID      (s_rvalid),
        .S_RLAST       (s_rlast),
        .ar_grant      (ar_grant),
        .ar_sel_master (ar_sel_master),
        .ar_sel_slave  (ar_sel_slave),
        .S_ARVALID     (s_arvalid_o),
        .M_ARREADY     (m_arready_o),
        .r_sel_slave   (r_sel_slave),
        .M_RVALID      (m_rvalid_o),
        .M_RLAST       (m_rlast_o),
        .M_RDECERR     (m_rdecerr_o),
        .S_RREADY      (s_rready_o),
        .slave_busy    (slave_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        addr_lo   = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
        addr_hi   = {32'h3FFF_FFFF, 32'h2FFF_FFFF, 32'h1FFF_FFFF, 32'h0FFF_FFFF};
        reset     = 1'b1;
        m_araddr  = '0;
        m_arvalid = '0;
        m_rready  = '0;
        s_arready = '0;
        s_rvalid  = '0;
        s_rlast   = '0;
        step();
        step();

        // Reset state
        chk("rst_grant", ar_grant, 2'b00);
        chk("rst_sel_master", ar_sel_master, 1'b0);
        chk("rst_sel_slave", ar_sel_slave, 2'd0);
        chk("rst_s_arvalid", s_arvalid_o, 4'b0000);
        chk("rst_m_arready", m_arready_o, 2'b00);
        chk("rst_m_rvalid", m_rvalid_o, 2'b00);
        chk("rst_m_rdecerr", m_rdecerr_o, 2'b00);
        chk("rst_s_rready", s_rready_o, 4'b0000);
        chk("rst_busy", slave_busy, 4'b0000);
        chk("rst_r_sel", r_sel_slave, 4'b0000);
        reset = 1'b0;
        #1;

        // Single master, 4-beat burst on S1
        m_araddr[31:0] = 32'h1000_0040;
        m_arvalid      = 2'b01;
        s_arready      = 4'hF;
        #1;
        chk("t1_idle_grant", ar_grant, 2'b00);
        chk("t1_idle_arready", m_arready_o, 2'b00);
        step();
        chk("t1_grant", ar_grant, 2'b01);
        chk("t1_sel_master", ar_sel_master, 1'b0);
        chk("t1_sel_slave", ar_sel_slave, 2'd1);
        chk("t1_s_arvalid", s_arvalid_o, 4'b0010);
        chk("t1_m_arready", m_arready_o, 2'b01);
        chk("t1_busy_pre", slave_busy, 4'b0000);
        step();
        m_arvalid = 2'b00;
        #1;
        $display("txn: M0 AR to S1 accepted");
        chk("t1_busy", slave_busy, 4'b0010);
        chk("t1_grant_clr", ar_grant, 2'b00);
        chk("t1_r_sel", r_sel_slave, 4'b0001);
        chk("t1_rvalid_idle", m_rvalid_o, 2'b00);
        m_rready = 2'b01;
        s_rvalid = 4'b0010;
        for (int b = 0; b < 4; b++) begin
            s_rlast = (b == 3) ? 4'b0010 : 4'b0000;
            #1;
            chk("t1_beat_rvalid", m_rvalid_o, 2'b01);
            chk("t1_beat_rlast", m_rlast_o, (b == 3) ? 2'b01 : 2'b00);
            chk("t1_beat_rready", s_rready_o, 4'b0010);
            chk("t1_beat_busy", slave_busy, 4'b0010);
            step();
            $display("txn: S1 beat %0d to M0", b);
        end
        s_rvalid = '0;
        s_rlast  = '0;
        #1;
        chk("t1_released", slave_busy, 4'b0000);
        chk("t1_rready_off", s_rready_o, 4'b0000);
        chk("t1_rvalid_off", m_rvalid_o, 2'b00);

        // Two masters in the same cycle from rr_ptr = 0
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_araddr  = {32'h3000_0000, 32'h0000_1000};
        m_arvalid = 2'b11;
        #1;
        step();
        chk("t2_grant_m0", ar_grant, 2'b01);
        chk("t2_sel_s0", ar_sel_slave, 2'd0);
        step();
        m_arvalid = 2'b10;
        #1;
        $display("txn: M0 AR to S0 accepted");
        chk("t2_gap_grant", ar_grant, 2'b00);
        chk("t2_busy_s0", slave_busy, 4'b0001);
        step();
        chk("t2_grant_m1", ar_grant, 2'b10);
        chk("t2_sel_m1", ar_sel_master, 1'b1);
        chk("t2_sel_s3", ar_sel_slave, 2'd3);
        chk("t2_s_arvalid", s_arvalid_o, 4'b1000);
        step();
        m_arvalid = 2'b00;
        #1;
        $display("txn: M1 AR to S3 accepted");
        chk("t2_busy_both", slave_busy, 4'b1001);
        chk("t2_r_sel", r_sel_slave, 4'b1100);
        s_rvalid = 4'b1001;
        s_rlast  = 4'b1001;
        m_rready = 2'b11;
        #1;
        chk("t2_rvalid", m_rvalid_o, 2'b11);
        chk("t2_rready", s_rready_o, 4'b1001);
        step();
        s_rvalid = '0;
        s_rlast  = '0;
        #1;
        $display("txn: S0->M0 and S3->M1 single beats");
        chk("t2_released", slave_busy, 4'b0000);

        // Contention on S2; rr_ptr wrapped to 0 so M0 wins
        m_araddr  = {32'h2000_0100, 32'h2000_0000};
        m_arvalid = 2'b11;
        m_rready  = 2'b00;
        #1;
        step();
        chk("t3_grant_m0", ar_grant, 2'b01);
        step();
        m_arvalid = 2'b10;
        #1;
        $display("txn: M0 AR to S2 accepted");
        chk("t3_busy", slave_busy, 4'b0100);
        chk("t3_grant_clr", ar_grant, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_blocked_grant", ar_grant, 2'b00);
            chk("t3_blocked_arready", m_arready_o, 2'b00);
        end
        m_rready = 2'b01;
        s_rvalid = 4'b0100;
        s_rlast  = 4'b0000;
        #1;
        step();
        s_rlast = 4'b0100;
        #1;
        chk("t3_last_grant", ar_grant, 2'b00);
        chk("t3_last_arready", m_arready_o, 2'b00);
        chk("t3_last_rlast", m_rlast_o, 2'b01);
        step();
        s_rvalid = '0;
        s_rlast  = '0;
        #1;
        $display("txn: S2 burst to M0 released");
        chk("t3_release_busy", slave_busy, 4'b0000);
        chk("t3_release_idle", ar_grant, 2'b00);
        step();
        chk("t3_grant_m1", ar_grant, 2'b10);
        chk("t3_sel_s2", ar_sel_slave, 2'd2);
        chk("t3_arready_m1", m_arready_o, 2'b10);
        step();
        m_arvalid = 2'b00;
        #1;
        $display("txn: M1 AR to S2 accepted");
        chk("t3_busy_m1", slave_busy, 4'b0100);
        chk("t3_r_sel_m1", r_sel_slave, 4'b1000);
        chk("t3_rready_m1_low", s_rready_o, 4'b0000);
        m_rready = 2'b10;
        s_rvalid = 4'b0100;
        s_rlast  = 4'b0100;
        #1;
        chk("t3_rready_m1", s_rready_o, 4'b0100);
        step();
        s_rvalid = '0;
        s_rlast  = '0;
        m_rready = '0;
        #1;
        chk("t3_done", slave_busy, 4'b0000);

        // Unmapped read from M1 gets an internal DECERR
        m_araddr[63:32] = 32'hF000_0000;
        m_arvalid       = 2'b10;
        #1;
        step();
        chk("t4_grant", ar_grant, 2'b10);
        chk("t4_arready", m_arready_o, 2'b10);
        chk("t4_no_s_arvalid", s_arvalid_o, 4'b0000);
        step();
        m_arvalid = 2'b00;
        #1;
        $display("txn: M1 AR to unmapped accepted");
        chk("t4_arready_pulse", m_arready_o, 2'b00);
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_rvalid", m_rvalid_o, 2'b10);
            chk("t4_hold_rlast", m_rlast_o, 2'b10);
            chk("t4_hold_decerr", m_rdecerr_o, 2'b10);
            step();
        end
        m_rready = 2'b10;
        #1;
        chk("t4_hs_rvalid", m_rvalid_o, 2'b10);
        step();
        m_rready = 2'b00;
        #1;
        $display("txn: M1 DECERR response accepted");
        chk("t4_clr_rvalid", m_rvalid_o, 2'b00);
        chk("t4_clr_decerr", m_rdecerr_o, 2'b00);

        // Back-pressure from M0 for five cycles
        m_araddr[31:0] = 32'h1000_0000;
        m_arvalid      = 2'b01;
        #1;
        step();
        chk("t5_grant", ar_grant, 2'b01);
        step();
        m_arvalid = 2'b00;
        s_rvalid  = 4'b0010;
        s_rlast   = 4'b0000;
        m_rready  = 2'b00;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_rready", s_rready_o, 4'b0000);
            chk("t5_stall_rvalid", m_rvalid_o, 2'b01);
            step();
        end
        chk("t5_stall_busy", slave_busy, 4'b0010);
        m_rready = 2'b01;
        #1;
        chk("t5_resume_rready", s_rready_o, 4'b0010);
        step();
        s_rlast = 4'b0010;
        #1;
        chk("t5_last", m_rlast_o, 2'b01);
        step();
        s_rvalid = '0;
        s_rlast  = '0;
        m_rready = '0;
        #1;
        $display("txn: S1 stalled burst to M0 released");
        chk("t5_released", slave_busy, 4'b0000);

        // Reset during ADDR (M1 waiting on S0) and mid-burst (M0 on S1)
        m_araddr[31:0] = 32'h1000_0000;
        m_arvalid      = 2'b01;
        #1;
        step();
        step();
        m_arvalid       = 2'b10;
        m_araddr[63:32] = 32'h0000_2000;
        s_arready       = 4'b0000;
        s_rvalid        = 4'b0010;
        m_rready        = 2'b01;
        #1;
        chk("t6_busy", slave_busy, 4'b0010);
        chk("t6_rready", s_rready_o, 4'b0010);
        step();
        chk("t6_addr_grant", ar_grant, 2'b10);
        chk("t6_addr_s_arvalid", s_arvalid_o, 4'b0001);
        chk("t6_addr_hold", m_arready_o, 2'b00);
        reset = 1'b1;
        #1;
        chk("t6_rst_grant", ar_grant, 2'b00);
        chk("t6_rst_s_arvalid", s_arvalid_o, 4'b0000);
        chk("t6_rst_busy", slave_busy, 4'b0000);
        chk("t6_rst_rready", s_rready_o, 4'b0000);
        chk("t6_rst_rvalid", m_rvalid_o, 2'b00);
        chk("t6_rst_r_sel", r_sel_slave, 4'b0000);
        chk("t6_rst_sel_master", ar_sel_master, 1'b0);
        reset     = 1'b0;
        s_rvalid  = '0;
        m_rready  = '0;
        s_arready = 4'hF;
        m_arvalid = 2'b11;
        #1;
        step();
        chk("t6_after_rst_grant", ar_grant, 2'b01);
        chk("t6_after_rst_sel", ar_sel_slave, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
